// File: rtl/march_bist_ctrl.sv
// March C- BIST initiator for a single-port memory: one op per clock, pipelined read checks.
// Optional build macro BIST_STOP_ON_FAIL_EN: abort the test at the first read mismatch.
module march_bist_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned CAPACITY   = 511,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    write_read,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]   rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [ADDR_WIDTH-1:0]   fail_addr,
    output logic [DATA_WIDTH-1:0]   fail_data,
    output logic [ADDR_WIDTH+3:0]   fail_cnt
);

    localparam int unsigned CNT_W   = ADDR_WIDTH + 4;
    localparam int unsigned DRAIN_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
    localparam logic [2:0] E_LAST = 3'd5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Element table: E0 w0 | E1 r0,w1 | E2 r1,w0 | E3v r0,w1 | E4v r1,w0 | E5 r0
    function automatic logic f_two_op(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic f_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic f_is_write(input logic [2:0] e, input logic ph);
        return (e == 3'd0) || (f_two_op(e) && ph);
    endfunction

    function automatic logic f_bit(input logic [2:0] e, input logic ph);
        return f_two_op(e) ? (e[0] ? ph : ~ph) : 1'b0;
    endfunction

    logic [1:0]            r_state, w_state_nxt;
    logic [2:0]            r_elem, w_elem_nxt;
    logic                  r_phase, w_phase_nxt;
    logic [ADDR_WIDTH-1:0] r_seq_addr, w_seq_addr_nxt;
    logic [DRAIN_W-1:0]    r_drain, w_drain_nxt;

    logic                  r_write_read, w_write_read_nxt;
    logic [ADDR_WIDTH-1:0] r_address, w_address_nxt;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_fail, w_fail_nxt;
    logic [ADDR_WIDTH-1:0] r_fail_addr, w_fail_addr_nxt;
    logic [DATA_WIDTH-1:0] r_fail_data, w_fail_data_nxt;
    logic [CNT_W-1:0]      r_fail_cnt, w_fail_cnt_nxt;

    logic [RD_LAT:0]                 r_pv;
    logic [RD_LAT:0][ADDR_WIDTH-1:0] r_pa;
    logic [RD_LAT:0]                 r_pe;
    logic                            w_push;
    logic                            w_flush;

    logic [2:0]            w_nx_elem;
    logic                  w_nx_phase;
    logic [ADDR_WIDTH-1:0] w_nx_addr;
    logic                  w_at_end;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_exp_word;
    logic                  w_mismatch;

    // Sequencer position that follows the op currently pointed at
    always_comb begin
        w_nx_elem  = r_elem;
        w_nx_phase = 1'b0;
        w_nx_addr  = r_seq_addr;
        w_at_end   = f_down(r_elem) ? (r_seq_addr == '0) : (r_seq_addr == LAST_ADDR);
        if (f_two_op(r_elem) && !r_phase) begin
            w_nx_phase = 1'b1;
        end else if (w_at_end) begin
            w_nx_elem = r_elem + 3'd1;
            w_nx_addr = f_down(r_elem + 3'd1) ? LAST_ADDR : '0;
        end else if (f_down(r_elem)) begin
            w_nx_addr = r_seq_addr - ADDR_WIDTH'(1);
        end else begin
            w_nx_addr = r_seq_addr + ADDR_WIDTH'(1);
        end
    end

    assign w_last     = (r_elem == E_LAST) && (r_seq_addr == LAST_ADDR);
    assign w_exp_word = {DATA_WIDTH{r_pe[RD_LAT]}};
    assign w_mismatch = r_pv[RD_LAT] && (rdata != w_exp_word);

    always_comb begin
        w_state_nxt      = r_state;
        w_elem_nxt       = r_elem;
        w_phase_nxt      = r_phase;
        w_seq_addr_nxt   = r_seq_addr;
        w_drain_nxt      = r_drain;
        w_write_read_nxt = 1'b0;
        w_address_nxt    = '0;
        w_wdata_nxt      = r_wdata;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_fail_nxt       = r_fail;
        w_fail_addr_nxt  = r_fail_addr;
        w_fail_data_nxt  = r_fail_data;
        w_fail_cnt_nxt   = r_fail_cnt;
        w_push           = 1'b0;
        w_flush          = 1'b0;

        if (w_mismatch) begin
            w_fail_nxt = 1'b1;
            if (!r_fail) begin
                w_fail_addr_nxt = r_pa[RD_LAT];
                w_fail_data_nxt = rdata;
            end
            if (r_fail_cnt != {CNT_W{1'b1}}) begin
                w_fail_cnt_nxt = r_fail_cnt + CNT_W'(1);
            end
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt     = S_RUN;
                    w_elem_nxt      = 3'd0;
                    w_phase_nxt     = 1'b0;
                    w_seq_addr_nxt  = '0;
                    w_wdata_nxt     = '0;
                    w_busy_nxt      = 1'b1;
                    w_done_nxt      = 1'b0;
                    w_fail_nxt      = 1'b0;
                    w_fail_addr_nxt = '0;
                    w_fail_data_nxt = '0;
                    w_fail_cnt_nxt  = '0;
                end
            end
            S_RUN: begin
                // Issue the pointed-at op; wdata is loaded one clock ahead of its write
                w_write_read_nxt = f_is_write(r_elem, r_phase);
                w_address_nxt    = r_seq_addr;
                w_push           = !f_is_write(r_elem, r_phase);
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = '0;
                end else begin
                    w_elem_nxt     = w_nx_elem;
                    w_phase_nxt    = w_nx_phase;
                    w_seq_addr_nxt = w_nx_addr;
                    if (f_is_write(w_nx_elem, w_nx_phase)) begin
                        w_wdata_nxt = {DATA_WIDTH{f_bit(w_nx_elem, w_nx_phase)}};
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_W'(RD_LAT)) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_drain_nxt = r_drain + DRAIN_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

`ifdef BIST_STOP_ON_FAIL_EN
        if (w_mismatch && ((r_state == S_RUN) || (r_state == S_DRAIN))) begin
            w_state_nxt      = S_DONE;
            w_busy_nxt       = 1'b0;
            w_done_nxt       = 1'b1;
            w_write_read_nxt = 1'b0;
            w_address_nxt    = '0;
            w_push           = 1'b0;
            w_flush          = 1'b1;
        end
`else
        w_flush = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_elem       <= '0;
            r_phase      <= 1'b0;
            r_seq_addr   <= '0;
            r_drain      <= '0;
            r_write_read <= 1'b0;
            r_address    <= '0;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
            r_fail_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_elem       <= w_elem_nxt;
            r_phase      <= w_phase_nxt;
            r_seq_addr   <= w_seq_addr_nxt;
            r_drain      <= w_drain_nxt;
            r_write_read <= w_write_read_nxt;
            r_address    <= w_address_nxt;
            r_wdata      <= w_wdata_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_fail       <= w_fail_nxt;
            r_fail_addr  <= w_fail_addr_nxt;
            r_fail_data  <= w_fail_data_nxt;
            r_fail_cnt   <= w_fail_cnt_nxt;
        end
    end

    // Expected-value/address pipeline aligned to the memory read latency
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_pv <= '0;
            r_pa <= '0;
            r_pe <= '0;
        end else begin
            r_pv <= {r_pv[RD_LAT-1:0], w_push};
            r_pa <= {r_pa[RD_LAT-1:0], r_seq_addr};
            r_pe <= {r_pe[RD_LAT-1:0], f_bit(r_elem, r_phase)};
        end
    end

    assign write_read = r_write_read;
    assign address    = r_address;
    assign wdata      = r_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;
    assign fail_addr  = r_fail_addr;
    assign fail_data  = r_fail_data;
    assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Scoreboard bench for march_bist_ctrl with a faultable two-stage-read memory model.
module tb_march_bist_ctrl;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 4;
    localparam int unsigned CAP  = 15;
    localparam int unsigned RDL  = 2;
    localparam int unsigned N    = CAP + 1;
    localparam int unsigned NOPS = 10 * N;
    localparam int unsigned CW   = AW + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          write_read;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [CW-1:0] fail_cnt;

    always #5 clk = ~clk;

    march_bist_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_cnt(fail_cnt)
    );

    // Memory under test: wdata registered once, read data registered twice
    logic [DW-1:0] mem [N];
    logic [DW-1:0] wd_q, rd1;
    logic          fault_en = 1'b0;
    logic [AW-1:0] fault_a = '0;
    logic [DW-1:0] fault_v = '0;

    always @(posedge clk) begin
        wd_q <= wdata;
        if (write_read) mem[address] <= wd_q;
        rd1   <= (fault_en && address == fault_a) ? fault_v : mem[address];
        rdata <= rd1;
    end

    typedef struct {
        int            at_edge;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } op_t;

    typedef struct {
        int            at_edge;
        logic          fail;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fdata;
        logic [CW-1:0] fcnt;
    } res_t;

    op_t  opq[$];
    res_t resq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Reference: walk the March C- element list and predict the op stream and verdict
    task automatic build_expect(input int s);
        logic [DW-1:0] rmem [N];
        int            first_val [6] = '{0, 0, 255, 0, 255, 0};
        int            k = 0;
        int            cnt = 0;
        logic          got_fail = 1'b0;
        logic [AW-1:0] fa = '0;
        logic [DW-1:0] fd = '0;
        res_t          r;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < int'(N); i++) begin
                int            a = (e == 3 || e == 4) ? int'(N) - 1 - i : i;
                logic [DW-1:0] v = DW'(first_val[e]);
                logic [DW-1:0] got;
                op_t           o;
                o.addr = AW'(a);
                if (e == 0) begin
                    o.at_edge = s + 1 + k; o.wr = 1'b1; o.wd = v;
                    opq.push_back(o); rmem[a] = v; k++;
                end else begin
                    o.at_edge = s + 1 + k; o.wr = 1'b0; o.wd = '0;
                    opq.push_back(o); k++;
                    got = (fault_en && AW'(a) == fault_a) ? fault_v : rmem[a];
                    if (got !== v) begin
                        if (!got_fail) begin got_fail = 1'b1; fa = AW'(a); fd = got; end
                        cnt++;
                    end
                    if (e != 5) begin
                        o.at_edge = s + 1 + k; o.wr = 1'b1; o.wd = ~v;
                        opq.push_back(o); rmem[a] = ~v; k++;
                    end
                end
            end
        end
        r.at_edge = s + int'(NOPS) + int'(RDL) + 1;
        r.fail    = got_fail;
        r.faddr   = fa;
        r.fdata   = fd;
        r.fcnt    = (cnt > 255) ? CW'(255) : CW'(cnt);
        resq.push_back(r);
    endtask

    // Monitor: pops expected ops by edge and expected verdicts on done rising
    initial begin
        logic          prev_done;
        logic [DW-1:0] prev_wd;
        logic [DW-1:0] act_wd, exp_wd;
        op_t           o;
        res_t          r;
        prev_done = 1'b0;
        prev_wd   = '0;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (opq.size() > 0 && opq[0].at_edge == edge_n) begin
                o      = opq.pop_front();
                act_wd = write_read ? prev_wd : DW'(0);
                exp_wd = o.wr ? o.wd : DW'(0);
                check("op", {busy, write_read, address, act_wd}, {1'b1, o.wr, o.addr, exp_wd});
            end
            if (done && !prev_done) begin
                if (resq.size() > 0) begin
                    r = resq.pop_front();
                    check("done_edge", 64'(edge_n), 64'(r.at_edge));
                    check("verdict", {busy, write_read, address, fail, fail_addr, fail_data, fail_cnt},
                          {1'b0, 1'b0, AW'(0), r.fail, r.faddr, r.fdata, r.fcnt});
                end else begin
                    check("unexpected_done", 64'(done), 64'(0));
                end
            end
            prev_done = done;
            prev_wd   = wdata;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        build_expect(edge_n + 1);
        @(negedge clk);
        start = 1'b0;
        check("start_clear", {busy, done, fail, fail_cnt}, {1'b1, 1'b0, 1'b0, CW'(0)});
    endtask

    task automatic wait_done(input int spur);
        int t = 0;
        while (resq.size() > 0 && t < int'(NOPS) + 50) begin
            @(negedge clk);
            t++;
            start = (t == spur);
        end
        start = 1'b0;
        if (resq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done after %0d cycles, expected 1", t);
            opq.delete();
            resq.delete();
        end
        check("ops_left", 64'(opq.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_cmd", {write_read, address, wdata}, '0);
        check("reset_status", {busy, done, fail, fail_addr, fail_data, fail_cnt}, '0);
        rst = 1'b0;

        fault_en = 1'b0;
        do_start();
        wait_done(0);

        fault_en = 1'b1; fault_a = AW'(5); fault_v = 8'hA5;
        do_start();
        wait_done(0);
        check("directed_fault", {fail, fail_addr, fail_data, fail_cnt}, {1'b1, AW'(5), 8'hA5, CW'(5)});

        for (int i = 0; i < 5; i++) begin
            fault_en = ($urandom_range(0, 3) != 0);
            fault_a  = AW'($urandom_range(0, CAP));
            fault_v  = DW'($urandom);
            do_start();
            wait_done($urandom_range(2, NOPS));
        end

        fault_en = 1'b1; fault_a = AW'($urandom_range(0, CAP)); fault_v = 8'h3C;
        do_start();
        repeat (5 * N + 5) @(negedge clk);
        rst = 1'b1;
        opq.delete();
        resq.delete();
        @(posedge clk);
        #2;
        check("midrun_reset", {write_read, address, wdata, busy, done, fail, fail_addr, fail_data, fail_cnt}, '0);
        @(negedge clk);
        rst = 1'b0;

        fault_en = 1'b0;
        do_start();
        wait_done(0);
        check("clean_after_reset", {fail, fail_cnt}, {1'b0, CW'(0)});

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
